// File: rtl/alarm_ctrl.sv
// Alarm controller: BCD alarm-time editing, match trigger, ring with auto-stop and snooze.
// Optional tone escalation in RING when ALARM_ESCALATE_EN is defined.
module alarm_ctrl #(
  parameter int unsigned BEEP_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h2,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m2,
  input  logic       sec_zero,
  input  logic       alarm_en,
  input  logic       set_key,
  input  logic       inc_key,
  input  logic       stop_key,
  input  logic       snooze_key,
  output logic [3:0] alm_h1,
  output logic [3:0] alm_h2,
  output logic [3:0] alm_m1,
  output logic [3:0] alm_m2,
  output logic [1:0] set_mode,
  output logic       beep_on,
  output logic [1:0] beep_tone,
  output logic       ringing
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetH   = 3'd1;
  localparam logic [2:0] StSetM   = 3'd2;
  localparam logic [2:0] StRing   = 3'd3;
  localparam logic [2:0] StSnooze = 3'd4;

  localparam logic [9:0] SnoozeTicks = 10'(SNOOZE_MIN * 60);
  localparam logic [7:0] BeepLast    = 8'(BEEP_SECS - 1);
`ifdef ALARM_ESCALATE_EN
  localparam logic [7:0] BeepHalf    = 8'(BEEP_SECS / 2);
`endif

  logic [2:0] state_q, state_d;
  logic [3:0] h1_q, h1_d, h2_q, h2_d, m1_q, m1_d, m2_q, m2_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [9:0] snz_cnt_q, snz_cnt_d;
  logic       beep_on_q, beep_on_d;
  logic [1:0] tone_q, tone_d;
  logic       ringing_q, ringing_d;
  logic [1:0] mode_q, mode_d;
  logic       match;

  assign match = alarm_en & tick_1hz & sec_zero &
                 (cur_h1 == h1_q) & (cur_h2 == h2_q) & (cur_m1 == m1_q) & (cur_m2 == m2_q);

  always_comb begin
    state_d    = state_q;
    h1_d       = h1_q;
    h2_d       = h2_q;
    m1_d       = m1_q;
    m2_d       = m2_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;

    case (state_q)
      StIdle: begin
        if (set_key) begin
          state_d = StSetH;
        end else if (match) begin
          state_d    = StRing;
          ring_cnt_d = 8'd0;
        end
      end
      StSetH: begin
        if (inc_key) begin
          if (h1_q == 4'd2 && h2_q == 4'd3) begin
            h1_d = 4'd0;
            h2_d = 4'd0;
          end else if (h2_q == 4'd9) begin
            h1_d = h1_q + 4'd1;
            h2_d = 4'd0;
          end else begin
            h2_d = h2_q + 4'd1;
          end
        end
        if (set_key) state_d = StSetM;
      end
      StSetM: begin
        // Minute wrap never carries into the hour digits.
        if (inc_key) begin
          if (m2_q == 4'd9) begin
            m2_d = 4'd0;
            m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
          end else begin
            m2_d = m2_q + 4'd1;
          end
        end
        if (set_key) state_d = StIdle;
      end
      StRing: begin
        if (!alarm_en || stop_key) begin
          state_d = StIdle;
        end else if (snooze_key) begin
          state_d   = StSnooze;
          snz_cnt_d = SnoozeTicks;
        end else if (tick_1hz) begin
          if (ring_cnt_q == BeepLast) state_d = StIdle;
          else ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
      StSnooze: begin
        if (!alarm_en || stop_key) begin
          state_d = StIdle;
        end else if (tick_1hz) begin
          if (snz_cnt_q == 10'd1) begin
            state_d    = StRing;
            ring_cnt_d = 8'd0;
          end else begin
            snz_cnt_d = snz_cnt_q - 10'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != StRing && state_d != StSnooze) begin
      ring_cnt_d = 8'd0;
      snz_cnt_d  = 10'd0;
    end

    // Outputs are registered from the next state so they change with the state.
    beep_on_d = (state_d == StRing);
    ringing_d = (state_d == StRing) || (state_d == StSnooze);
`ifdef ALARM_ESCALATE_EN
    tone_d = (state_d != StRing) ? 2'b00 : (ring_cnt_d < BeepHalf) ? 2'b01 : 2'b10;
`else
    tone_d = (state_d == StRing) ? 2'b01 : 2'b00;
`endif
    mode_d = (state_d == StSetH) ? 2'b01 : (state_d == StSetM) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      h1_q       <= 4'd0;
      h2_q       <= 4'd0;
      m1_q       <= 4'd0;
      m2_q       <= 4'd0;
      ring_cnt_q <= 8'd0;
      snz_cnt_q  <= 10'd0;
      beep_on_q  <= 1'b0;
      tone_q     <= 2'b00;
      ringing_q  <= 1'b0;
      mode_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      h1_q       <= h1_d;
      h2_q       <= h2_d;
      m1_q       <= m1_d;
      m2_q       <= m2_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      beep_on_q  <= beep_on_d;
      tone_q     <= tone_d;
      ringing_q  <= ringing_d;
      mode_q     <= mode_d;
    end
  end

  assign alm_h1    = h1_q;
  assign alm_h2    = h2_q;
  assign alm_m1    = m1_q;
  assign alm_m2    = m2_q;
  assign set_mode  = mode_q;
  assign beep_on   = beep_on_q;
  assign beep_tone = tone_q;
  assign ringing   = ringing_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_alarm_ctrl;

  localparam int BeepSecs  = 60;
  localparam int SnoozeMin = 5;

  localparam int MIdle   = 0;
  localparam int MSetH   = 1;
  localparam int MSetM   = 2;
  localparam int MRing   = 3;
  localparam int MSnooze = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [3:0] cur_h1 = '0, cur_h2 = '0, cur_m1 = '0, cur_m2 = '0;
  logic       sec_zero = 1'b0;
  logic       alarm_en = 1'b0;
  logic       set_key = 1'b0, inc_key = 1'b0, stop_key = 1'b0, snooze_key = 1'b0;
  logic [3:0] alm_h1, alm_h2, alm_m1, alm_m2;
  logic [1:0] set_mode;
  logic       beep_on;
  logic [1:0] beep_tone;
  logic       ringing;

  alarm_ctrl #(
    .BEEP_SECS (BeepSecs),
    .SNOOZE_MIN(SnoozeMin)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .cur_h1    (cur_h1),
    .cur_h2    (cur_h2),
    .cur_m1    (cur_m1),
    .cur_m2    (cur_m2),
    .sec_zero  (sec_zero),
    .alarm_en  (alarm_en),
    .set_key   (set_key),
    .inc_key   (inc_key),
    .stop_key  (stop_key),
    .snooze_key(snooze_key),
    .alm_h1    (alm_h1),
    .alm_h2    (alm_h2),
    .alm_m1    (alm_m1),
    .alm_m2    (alm_m2),
    .set_mode  (set_mode),
    .beep_on   (beep_on),
    .beep_tone (beep_tone),
    .ringing   (ringing)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: mode, alarm time as plain hours/minutes, seconds rung, seconds of snooze left.
  int m_st = MIdle;
  int ah = 0, am = 0;
  int rs = 0, sl = 0;
  int ch = 0, cm = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic int bcd_time(input int h, input int m);
    return ((h / 10) << 12) | ((h % 10) << 8) | ((m / 10) << 4) | (m % 10);
  endfunction

  task automatic model_step();
    bit match;
    match = alarm_en && tick_1hz && sec_zero && (ch == ah) && (cm == am);
    if (rst) begin
      m_st = MIdle; ah = 0; am = 0; rs = 0; sl = 0;
      return;
    end
    case (m_st)
      MIdle: begin
        if (set_key) m_st = MSetH;
        else if (match) begin m_st = MRing; rs = 0; end
      end
      MSetH: begin
        if (inc_key) ah = (ah + 1) % 24;
        if (set_key) m_st = MSetM;
      end
      MSetM: begin
        if (inc_key) am = (am + 1) % 60;
        if (set_key) m_st = MIdle;
      end
      MRing: begin
        if (!alarm_en || stop_key) m_st = MIdle;
        else if (snooze_key) begin m_st = MSnooze; sl = SnoozeMin * 60; end
        else if (tick_1hz) begin
          rs++;
          if (rs == BeepSecs) m_st = MIdle;
        end
      end
      default: begin
        if (!alarm_en || stop_key) m_st = MIdle;
        else if (tick_1hz) begin
          sl--;
          if (sl == 0) begin m_st = MRing; rs = 0; end
        end
      end
    endcase
    if (m_st == MIdle) begin rs = 0; sl = 0; end
  endtask

  function automatic int exp_tone();
    if (m_st != MRing) return 0;
`ifdef ALARM_ESCALATE_EN
    return (rs < BeepSecs / 2) ? 1 : 2;
`else
    return 1;
`endif
  endfunction

  // One clock: model follows the inputs, DUT is sampled 1 time unit after the edge.
  task automatic cyc();
    cur_h1 = 4'(ch / 10);
    cur_h2 = 4'(ch % 10);
    cur_m1 = 4'(cm / 10);
    cur_m2 = 4'(cm % 10);
    model_step();
    @(posedge clk);
    #1;
    check("beep_on", int'(beep_on), (m_st == MRing) ? 1 : 0);
    check("beep_tone", int'(beep_tone), exp_tone());
    check("ringing", int'(ringing), (m_st == MRing || m_st == MSnooze) ? 1 : 0);
    check("set_mode", int'(set_mode), (m_st == MSetH) ? 1 : (m_st == MSetM) ? 2 : 0);
    check("alm", int'({alm_h1, alm_h2, alm_m1, alm_m2}), bcd_time(ah, am));
    rst = 0; tick_1hz = 0; set_key = 0; inc_key = 0; stop_key = 0; snooze_key = 0;
  endtask

  task automatic key_set();
    set_key = 1; cyc();
  endtask

  task automatic key_inc(input int n);
    for (int i = 0; i < n; i++) begin inc_key = 1; cyc(); end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin tick_1hz = 1; cyc(); cyc(); end
  endtask

  task automatic trigger();
    ch = ah; cm = am; sec_zero = 1; alarm_en = 1; tick_1hz = 1; cyc();
    sec_zero = 0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1; cyc();
    check("rst_mode", int'(set_mode), 0);
    check("rst_alm", int'({alm_h1, alm_h2, alm_m1, alm_m2}), 0);

    // Set path to 03:07
    key_set();
    check("sp_mode_h", int'(set_mode), 1);
    key_inc(3);
    key_set();
    check("sp_mode_m", int'(set_mode), 2);
    key_inc(7);
    key_set();
    check("sp_mode_idle", int'(set_mode), 0);
    check("sp_alm", int'({alm_h1, alm_h2, alm_m1, alm_m2}), 'h0307);

    // Hour and minute wrap
    key_set();
    key_inc(20);
    check("wrap_h23", int'({alm_h1, alm_h2}), 'h23);
    key_inc(1);
    check("wrap_h00", int'({alm_h1, alm_h2}), 'h00);
    key_set();
    key_inc(52);
    check("wrap_m59", int'({alm_m1, alm_m2}), 'h59);
    key_inc(1);
    check("wrap_m00", int'({alm_h1, alm_h2, alm_m1, alm_m2}), 'h0000);
    key_set();

    // Program 06:30 and trigger, then ring out
    key_set(); key_inc(6); key_set(); key_inc(30); key_set();
    check("alm_0630", int'({alm_h1, alm_h2, alm_m1, alm_m2}), 'h0630);
    trigger();
    check("trig_beep", int'(beep_on), 1);
    check("trig_tone", int'(beep_tone), 1);
    ticks(29);
    check("tone_t29", int'(beep_tone), 1);
    ticks(1);
`ifdef ALARM_ESCALATE_EN
    check("tone_t30", int'(beep_tone), 2);
`else
    check("tone_t30", int'(beep_tone), 1);
`endif
    ticks(29);
    check("ring_t59", int'(beep_on), 1);
    ticks(1);
    check("ring_t60_beep", int'(beep_on), 0);
    check("ring_t60_ringing", int'(ringing), 0);

    // Snooze for 300 ticks then ring again from a cleared counter
    trigger();
    ticks(10);
    snooze_key = 1; cyc();
    check("snz_beep", int'(beep_on), 0);
    check("snz_ringing", int'(ringing), 1);
    check("snz_tone", int'(beep_tone), 0);
    ticks(299);
    check("snz_t299", int'(beep_on), 0);
    ticks(1);
    check("snz_t300", int'(beep_on), 1);
    ticks(59);
    check("snz_ring_t59", int'(beep_on), 1);
    ticks(1);
    check("snz_ring_t60", int'(beep_on), 0);

    // Priorities
    trigger();
    stop_key = 1; snooze_key = 1; cyc();
    check("prio_stop", int'(ringing), 0);
    trigger();
    snooze_key = 1; cyc();
    alarm_en = 0; cyc();
    check("prio_en_snz", int'(ringing), 0);
    trigger();
    rst = 1; cyc();
    check("rst_ring_beep", int'(beep_on), 0);
    check("rst_ring_alm", int'({alm_h1, alm_h2, alm_m1, alm_m2}), 0);

    // Match blocked in SET_M; set_key beats a match in IDLE
    key_set(); key_set();
    ch = 0; cm = 0; sec_zero = 1; alarm_en = 1;
    tick_1hz = 1; cyc();
    check("blk_ringing", int'(ringing), 0);
    check("blk_mode", int'(set_mode), 2);
    tick_1hz = 1; inc_key = 1; cyc();
    check("blk_alm", int'({alm_h1, alm_h2, alm_m1, alm_m2}), 'h0001);
    key_set();
    cm = 1; set_key = 1; tick_1hz = 1; cyc();
    check("setwin_mode", int'(set_mode), 1);
    check("setwin_ring", int'(ringing), 0);
    key_set(); key_set();
    sec_zero = 0;

    // Random phase
    for (int i = 0; i < 8000; i++) begin
      rst        = ($urandom_range(0, 799) == 0);
      alarm_en   = ($urandom_range(0, 29) != 0);
      tick_1hz   = ($urandom_range(0, 2) == 0);
      sec_zero   = ($urandom_range(0, 1) == 0);
      set_key    = ($urandom_range(0, 59) == 0);
      inc_key    = ($urandom_range(0, 3) == 0);
      stop_key   = ($urandom_range(0, 149) == 0);
      snooze_key = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) != 0) begin
        ch = ah; cm = am;
      end else begin
        ch = $urandom_range(0, 23); cm = $urandom_range(0, 59);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
